// File: rtl/debounce_sync.sv
// debounce_sync
//   Synchronises a raw, bouncing push-button pin and turns it into a clean
//   active-high "pressed" level. A change in the synchronised sample must
//   hold for STABLE_COUNT consecutive clocks before Level follows it.
//
// Parameters
//   STABLE_COUNT : consecutive stable samples needed to change Level (2 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH    : width of the stability counter
//   ACTIVE_LOW   : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//
// Ports
//   Clock  : system clock, rising edge
//   Reset  : synchronous active-high reset
//   Button : raw asynchronous button pin
//   Level  : debounced pressed level (registered)
//   Busy   : high while a candidate transition is being qualified (registered)
module debounce_sync #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Level,
  output logic Busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  logic                 sample;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-flop synchroniser; the only logic that sees the asynchronous pin.
  // On reset both flops hold the released pin value so no phantom press
  // is seen when reset drops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= Button;
      sync2 <= sync1;
    end
  end

  // Normalise polarity: sample is 1 while pressed.
  assign sample = sync2 ^ ACTIVE_LOW;

  // Qualification FSM. Level and Busy are registered together with the
  // state so both outputs are glitch-free.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      Level <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        IDLE_LOW: begin
          if (sample) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
            Busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            Busy  <= 1'b0;
          end
          Level <= 1'b0;
        end
        WAIT_HIGH: begin
          if (!sample) begin
            // Any opposing sample restarts qualification.
            state <= IDLE_LOW;
            cnt   <= '0;
            Level <= 1'b0;
            Busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            Level <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
            Level <= 1'b0;
            Busy  <= 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sample) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
            Busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            Busy  <= 1'b0;
          end
          Level <= 1'b1;
        end
        WAIT_LOW: begin
          if (sample) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            Level <= 1'b1;
            Busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            Level <= 1'b0;
            Busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
            Level <= 1'b1;
            Busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          Level <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
